// File: rtl/vectored_int_ctrl.sv
// vectored_int_ctrl
//   Synchronous multi-source vectored interrupt controller for the multicycle
//   MIPS core. Provides NUM_IRQ prioritised, maskable, edge-triggered lines
//   (line 0 = highest priority) and a nested in-service stack of saved PCs
//   that is pushed on interrupt entry and popped by RFE.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   i_irq          asynchronous request lines, rising-edge sensitive
//   i_mask_we      load mask register
//   i_mask_wdata   new mask (1 = line enabled)
//   o_mask_q       current mask
//   i_pc_in        PC saved on interrupt entry
//   i_int_ack      CU commits to interrupt entry (1-cycle pulse)
//   i_rfe          CU executes RFE (1-cycle pulse)
//   o_int_req      serviceable interrupt waiting
//   o_vector_out   vector of the arbitrated line
//   o_int_id       arbitrated line id
//   o_epc_out      saved PC at stack top, 0 when empty
//   o_depth        number of in-service interrupts
//   o_err          sticky errors: [0] rfe on empty stack,
//                  [1] ack together with rfe, or ack without a request
module vectored_int_ctrl #(
  parameter int unsigned       NUM_IRQ         = 8,
  parameter int unsigned       ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE        = ADDR_W'(32'h0000_0100),
  parameter int unsigned       VEC_STRIDE_LOG2 = 4,
  parameter int unsigned       NEST_DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_IRQ-1:0]              i_irq,
  input  logic                            i_mask_we,
  input  logic [NUM_IRQ-1:0]              i_mask_wdata,
  output logic [NUM_IRQ-1:0]              o_mask_q,
  input  logic [ADDR_W-1:0]               i_pc_in,
  input  logic                            i_int_ack,
  input  logic                            i_rfe,
  output logic                            o_int_req,
  output logic [ADDR_W-1:0]               o_vector_out,
  output logic [$clog2(NUM_IRQ)-1:0]      o_int_id,
  output logic [ADDR_W-1:0]               o_epc_out,
  output logic [$clog2(NEST_DEPTH+1)-1:0] o_depth,
  output logic [1:0]                      o_err
);

  localparam int unsigned IW  = $clog2(NUM_IRQ);
  localparam int unsigned DW  = $clog2(NEST_DEPTH + 1);
  localparam int unsigned SPW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SERVICING = 2'd1,
    ST_FULL      = 2'd2
  } state_t;

  // Synchroniser (r_sync1, r_sync2) and edge register (r_sync3)
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;
  logic [NUM_IRQ-1:0] r_sync3;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_mask;

  logic               r_int_req;
  logic [IW-1:0]      r_int_id;
  logic [ADDR_W-1:0]  r_vector;
  logic [ADDR_W-1:0]  r_epc;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DW-1:0]      r_depth;
  logic [DW-1:0]      w_depth_nxt;
  logic [1:0]         r_err;
  logic [1:0]         w_err_nxt;

  logic [ADDR_W-1:0]  r_stk_pc [NEST_DEPTH];
  logic [IW-1:0]      r_stk_id [NEST_DEPTH];

  logic               w_push;
  logic               w_pop;
  logic               w_cand_vld;
  logic [IW-1:0]      w_cand;
  logic               w_req_c;
  logic [SPW-1:0]     w_top_idx;
  logic [SPW-1:0]     w_push_idx;
  logic [SPW-1:0]     w_below_idx;
  logic [IW-1:0]      w_top_id;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_pend_nxt;

  function automatic logic [ADDR_W-1:0] f_vec(input logic [IW-1:0] id);
    return VEC_BASE + (ADDR_W'(id) << VEC_STRIDE_LOG2);
  endfunction

  // Stack indices; top index is forced to 0 when empty to stay in range
  assign w_top_idx   = (r_depth == '0) ? '0 : SPW'(r_depth - DW'(1));
  assign w_push_idx  = SPW'(r_depth);
  assign w_below_idx = SPW'(r_depth - DW'(2));
  assign w_top_id    = r_stk_id[w_top_idx];

  // Priority encoder: lowest enabled pending line wins
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand     = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r_pend[i] && r_mask[i]) begin
        w_cand_vld = 1'b1;
        w_cand     = IW'(i);
      end
    end
  end

  // Serviceable only if there is room and it strictly preempts the current top
  assign w_req_c = w_cand_vld && (r_state != ST_FULL) &&
                   ((r_state == ST_IDLE) || (w_cand < w_top_id));

  // Next-state: rfe takes precedence over ack; errors are sticky
  always_comb begin
    w_state_nxt = r_state;
    w_depth_nxt = r_depth;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    if (i_rfe) begin
      if (r_state == ST_IDLE) begin
        w_err_nxt[0] = 1'b1;
      end else begin
        w_pop       = 1'b1;
        w_depth_nxt = r_depth - DW'(1);
      end
      if (i_int_ack) begin
        w_err_nxt[1] = 1'b1;
      end
    end else if (i_int_ack) begin
      if (r_int_req && (r_state != ST_FULL)) begin
        w_push      = 1'b1;
        w_depth_nxt = r_depth + DW'(1);
      end else begin
        w_err_nxt[1] = 1'b1;
      end
    end
    if (w_depth_nxt == '0) begin
      w_state_nxt = ST_IDLE;
    end else if (w_depth_nxt == DW'(NEST_DEPTH)) begin
      w_state_nxt = ST_FULL;
    end else begin
      w_state_nxt = ST_SERVICING;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_depth <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_depth <= w_depth_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // A new edge on the acked line in the ack cycle wins over the clear
  assign w_rise     = r_sync2 & ~r_sync3;
  assign w_clr      = w_push ? (NUM_IRQ'(1) << r_int_id) : '0;
  assign w_pend_nxt = (r_pend & ~w_clr) | w_rise;

  // Datapath: synchroniser, pending, mask, arbitration outputs, stack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_sync3   <= '0;
      r_pend    <= '0;
      r_mask    <= '1;
      r_int_req <= 1'b0;
      r_int_id  <= '0;
      r_vector  <= VEC_BASE;
      r_epc     <= '0;
      for (int k = 0; k < NEST_DEPTH; k++) begin
        r_stk_pc[k] <= '0;
        r_stk_id[k] <= '0;
      end
    end else begin
      r_sync1   <= i_irq;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_pend    <= w_pend_nxt;
      if (i_mask_we) begin
        r_mask <= i_mask_wdata;
      end
      // An accepted ack withdraws the request until the new stack top is seen
      r_int_req <= w_req_c && !w_push;
      if (w_cand_vld) begin
        r_int_id <= w_cand;
        r_vector <= f_vec(w_cand);
      end
      if (w_push) begin
        r_stk_pc[w_push_idx] <= i_pc_in;
        r_stk_id[w_push_idx] <= r_int_id;
        r_epc                <= i_pc_in;
      end else if (w_pop) begin
        r_epc <= (r_depth > DW'(1)) ? r_stk_pc[w_below_idx] : '0;
      end
    end
  end

  assign o_mask_q     = r_mask;
  assign o_int_req    = r_int_req;
  assign o_vector_out = r_vector;
  assign o_int_id     = r_int_id;
  assign o_epc_out    = r_epc;
  assign o_depth      = r_depth;
  assign o_err        = r_err;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// tb_vectored_int_ctrl
//   Bench for vectored_int_ctrl: directed scenarios followed by random
//   traffic, all checked every cycle against a queue-based reference model.
module tb_vectored_int_ctrl;

  localparam int unsigned NI = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned ND = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] irq;
  logic          mask_we;
  logic [NI-1:0] mask_wdata;
  logic [NI-1:0] mask_q;
  logic [AW-1:0] pc_in;
  logic          int_ack;
  logic          rfe;
  logic          int_req;
  logic [AW-1:0] vector_out;
  logic [2:0]    int_id;
  logic [AW-1:0] epc_out;
  logic [2:0]    depth;
  logic [1:0]    err;

  vectored_int_ctrl #(
    .NUM_IRQ(NI), .ADDR_W(AW), .VEC_BASE(32'h0000_0100),
    .VEC_STRIDE_LOG2(4), .NEST_DEPTH(ND)
  ) dut (
    .clk(clk), .rst(rst), .i_irq(irq), .i_mask_we(mask_we),
    .i_mask_wdata(mask_wdata), .o_mask_q(mask_q), .i_pc_in(pc_in),
    .i_int_ack(int_ack), .i_rfe(rfe), .o_int_req(int_req),
    .o_vector_out(vector_out), .o_int_id(int_id), .o_epc_out(epc_out),
    .o_depth(depth), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] pc;
  } frame_t;

  frame_t        m_stk[$];
  logic [NI-1:0] m_seen [3];   // irq samples from 1, 2 and 3 edges ago
  logic [NI-1:0] m_pend;
  logic [NI-1:0] m_mask;
  logic          m_req;
  logic [2:0]    m_id;
  logic [31:0]   m_vec;
  logic [1:0]    m_err;

  task automatic model_edge();
    logic [NI-1:0] rise;
    logic          rfe_ok, ack_ok, found, serv;
    int            cand;
    logic [2:0]    acked;
    if (rst) begin
      m_stk.delete();
      for (int k = 0; k < 3; k++) m_seen[k] = '0;
      m_pend = '0; m_mask = '1; m_req = 1'b0; m_id = '0;
      m_vec = 32'h100; m_err = '0;
      return;
    end
    // A line rising between the samples taken 3 and 2 edges ago lands now
    rise = m_seen[1] & ~m_seen[2];
    m_seen[2] = m_seen[1];
    m_seen[1] = m_seen[0];
    m_seen[0] = irq;
    rfe_ok = rfe && (m_stk.size() > 0);
    ack_ok = int_ack && m_req && !rfe;
    if (rfe && m_stk.size() == 0) m_err[0] = 1'b1;
    if (int_ack && (rfe || !m_req)) m_err[1] = 1'b1;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NI; i++) begin
      if (!found && m_pend[i] && m_mask[i]) begin
        found = 1'b1;
        cand  = i;
      end
    end
    serv  = found && (m_stk.size() < ND) &&
            (m_stk.size() == 0 || cand < int'(m_stk[$].id));
    acked = m_id;
    if (found) begin
      m_id  = 3'(cand);
      m_vec = 32'h100 + 32'(cand * 16);
    end
    if (ack_ok) begin
      m_pend[acked] = 1'b0;
      m_stk.push_back('{id: acked, pc: pc_in});
    end
    m_pend = m_pend | rise;
    if (rfe_ok) void'(m_stk.pop_back());
    if (mask_we) m_mask = mask_wdata;
    m_req = serv && !ack_ok;
  endtask

  // One clock: advance model with the inputs seen at the edge, then compare
  task automatic tick();
    logic [31:0] exp_epc;
    @(posedge clk);
    model_edge();
    #1;
    exp_epc = (m_stk.size() > 0) ? m_stk[$].pc : 32'h0;
    chk("int_req", 64'(int_req), 64'(m_req));
    chk("depth", 64'(depth), 64'(m_stk.size()));
    chk("epc_out", 64'(epc_out), 64'(exp_epc));
    chk("mask_q", 64'(mask_q), 64'(m_mask));
    chk("err", 64'(err), 64'(m_err));
    if (m_req) begin
      chk("int_id", 64'(int_id), 64'(m_id));
      chk("vector_out", 64'(vector_out), 64'(m_vec));
    end
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!int_req && n < budget) begin
      tick();
      n++;
    end
    chk("wait_req", 64'(int_req), 64'd1);
  endtask

  task automatic raise_and_ack(input int line, input logic [31:0] pc);
    irq[line] = 1'b1;
    wait_req(10);
    chk("ack_line", 64'(int_id), 64'(line));
    int_ack = 1'b1;
    pc_in   = pc;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0;
    pc_in = '0; int_ack = 1'b0; rfe = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_int_req", 64'(int_req), 64'd0);
    chk("rst_mask", 64'(mask_q), 64'hFF);
    chk("rst_depth", 64'(depth), 64'd0);
    chk("rst_vector", 64'(vector_out), 64'h100);
    chk("rst_int_id", 64'(int_id), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_epc", 64'(epc_out), 64'd0);

    // Latency: request appears on the 4th edge after the irq edge
    irq = 8'h08;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("lat_early", 64'(int_req), 64'd0);
    end
    tick();
    chk("lat_req", 64'(int_req), 64'd1);
    chk("lat_id", 64'(int_id), 64'd3);
    chk("lat_vec", 64'(vector_out), 64'h130);
    int_ack = 1'b1; pc_in = 32'h400;
    tick();
    int_ack = 1'b0; irq = '0;
    chk("ack_depth", 64'(depth), 64'd1);
    chk("ack_epc", 64'(epc_out), 64'h400);
    chk("ack_req_drop", 64'(int_req), 64'd0);
    rfe = 1'b1;
    tick();
    rfe = 1'b0;
    chk("rfe_depth", 64'(depth), 64'd0);
    chk("rfe_epc", 64'(epc_out), 64'd0);

    // Priority: lines 5 and 2 together
    irq = 8'h24;
    wait_req(8);
    chk("prio_first", 64'(int_id), 64'd2);
    int_ack = 1'b1; pc_in = 32'h500;
    tick();
    int_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("prio_blocked", 64'(int_req), 64'd0);
    end
    rfe = 1'b1;
    tick();
    rfe = 1'b0;
    tick();
    chk("prio_second", 64'(int_req), 64'd1);
    chk("prio_second_id", 64'(int_id), 64'd5);
    chk("prio_second_vec", 64'(vector_out), 64'h150);
    int_ack = 1'b1; pc_in = 32'h600;
    tick();
    int_ack = 1'b0; rfe = 1'b1;
    tick();
    rfe = 1'b0;

    // Mask: masked line still latches pending
    mask_we = 1'b1; mask_wdata = 8'hF7;
    tick();
    mask_we = 1'b0;
    irq = 8'h2C;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("masked_no_req", 64'(int_req), 64'd0);
    end
    mask_we = 1'b1; mask_wdata = 8'hFF;
    tick();
    mask_we = 1'b0;
    tick();
    chk("unmask_req", 64'(int_req), 64'd1);
    chk("unmask_id", 64'(int_id), 64'd3);
    int_ack = 1'b1; pc_in = 32'h700;
    tick();
    int_ack = 1'b0; rfe = 1'b1;
    tick();
    rfe = 1'b0; irq = '0;
    tick();

    // Errors
    rfe = 1'b1;
    tick();
    rfe = 1'b0;
    chk("err_rfe_empty", 64'(err), 64'b01);
    chk("err_rfe_depth", 64'(depth), 64'd0);
    raise_and_ack(4, 32'h800);
    int_ack = 1'b1; rfe = 1'b1;
    tick();
    int_ack = 1'b0; rfe = 1'b0;
    chk("err_both_depth", 64'(depth), 64'd0);
    chk("err_both", 64'(err), 64'b11);

    // Nesting to FULL, then RFE lets line 0 through
    rst = 1'b1; irq = '0;
    tick();
    rst = 1'b0;
    tick();
    raise_and_ack(6, 32'h1000);
    raise_and_ack(4, 32'h1100);
    raise_and_ack(2, 32'h1200);
    raise_and_ack(1, 32'h1300);
    chk("full_depth", 64'(depth), 64'd4);
    chk("full_epc", 64'(epc_out), 64'h1300);
    irq[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("full_no_req", 64'(int_req), 64'd0);
    end
    rfe = 1'b1;
    tick();
    rfe = 1'b0;
    chk("pop_epc", 64'(epc_out), 64'h1200);
    tick();
    chk("after_full_req", 64'(int_req), 64'd1);
    chk("after_full_id", 64'(int_id), 64'd0);

    // Reset mid-service clears everything
    mask_we = 1'b1; mask_wdata = 8'h0F;
    tick();
    mask_we = 1'b0; rst = 1'b1; irq = '0;
    tick();
    rst = 1'b0;
    chk("midrst_depth", 64'(depth), 64'd0);
    chk("midrst_mask", 64'(mask_q), 64'hFF);
    chk("midrst_req", 64'(int_req), 64'd0);
    chk("midrst_epc", 64'(epc_out), 64'd0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int b = 0; b < NI; b++) begin
        if ($urandom_range(0, 15) == 0) irq[b] = ~irq[b];
      end
      int_ack    = m_req ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 49) == 0);
      rfe        = ($urandom_range(0, 24) == 0);
      mask_we    = ($urandom_range(0, 39) == 0);
      mask_wdata = 8'($urandom);
      pc_in      = $urandom;
      tick();
    end

    rst = 1'b0; int_ack = 1'b0; rfe = 1'b0; mask_we = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
